// File: rtl/prog_clock_div_pkg.sv
// prog_clock_div_pkg: shared mode encodings and default divisor for the programmable clock divider
package prog_clock_div_pkg;
  typedef enum logic {MODE_TOGGLE = 1'b0, MODE_PULSE = 1'b1} modeT;
  localparam int unsigned DEFAULT_DIVISOR = 4999999;
endpackage

// File: rtl/prog_clock_div_if.sv
// prog_clock_div_if: enable/load handshake and divided outputs of the clock divider
interface prog_clock_div_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 23
);
  logic [CHANNELS-1:0] enable;
  logic [CHANNELS-1:0] clkOut;
  logic loadValid;
  logic loadReady;
  logic loadMode;
  logic [3:0] loadChan;
  logic [WIDTH-1:0] loadDiv;
  modport master(output enable, loadValid, loadChan, loadDiv, loadMode, input loadReady, clkOut);
  modport slave(input enable, loadValid, loadChan, loadDiv, loadMode, output loadReady, clkOut);
endinterface

// File: rtl/prog_clock_div_channel.sv
// div_channel: one divider channel with a pending divisor slot applied on period boundaries
module div_channel
  import prog_clock_div_pkg::*;
#(
  parameter int WIDTH = 23,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIVISOR
) (
  input  logic             clkIn,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] loadDiv,
  input  modeT             loadMode,
  output logic             pendValid,
  output logic             clkOut
);
  logic [WIDTH-1:0] cnt, div, pendDiv;
  modeT mode, pendMode;
  logic wrap, apply, modeChange;
  // a disabled channel has no period to protect, so its pending load lands at once
  always_comb begin
    wrap = enable && cnt == div;
    apply = pendValid && (wrap || !enable);
    modeChange = apply && pendMode != mode;
  end
  always_ff @(posedge clkIn) begin
    if (rst) begin
      cnt <= '0;
      div <= WIDTH'(DEFAULT_DIV);
      mode <= MODE_TOGGLE;
      pendValid <= 1'b0;
      clkOut <= 1'b0;
    end else begin
      cnt <= (wrap || !enable) ? '0 : cnt + 1'b1;
      clkOut <= (!enable || modeChange) ? 1'b0 : (mode == MODE_PULSE) ? wrap : clkOut ^ wrap;
      if (apply) begin
        div <= pendDiv;
        mode <= pendMode;
      end
      if (load) begin
        pendDiv <= loadDiv;
        pendMode <= loadMode;
      end
      pendValid <= load || (pendValid && !apply);
    end
  end
endmodule

// File: rtl/prog_clock_div.sv
// prog_clock_div: CHANNELS independent programmable dividers sharing one divisor-load port
module prog_clock_div
  import prog_clock_div_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 23,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIVISOR
) (
  input logic clkIn,
  input logic rst,
  prog_clock_div_if.slave bus
);
  logic [CHANNELS-1:0] ready, pend, load, outs;
  // out-of-range channel indices match no slot, so loadReady stays low for them
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) ready[i] = !rst && bus.loadChan == 4'(i) && !pend[i];
    load = bus.loadValid ? ready : '0;
  end
  assign bus.loadReady = |ready;
  assign bus.clkOut = outs;
  genvar c;
  for (c = 0; c < CHANNELS; c++) begin : gCh
    div_channel #(.WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV)) uCh (
      .clkIn(clkIn),
      .rst(rst),
      .enable(bus.enable[c]),
      .load(load[c]),
      .loadDiv(bus.loadDiv),
      .loadMode(modeT'(bus.loadMode)),
      .pendValid(pend[c]),
      .clkOut(outs[c])
    );
  end
endmodule

// File: tb/tb_prog_clock_div.sv
// tb_prog_clock_div: directed stimulus with a wrap-time model of every channel checked each cycle
module tb_prog_clock_div;
  localparam int CH = 4;
  localparam int W = 23;
  localparam int DD = 10;
  logic clkIn = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  prog_clock_div_if #(.CHANNELS(CH), .WIDTH(W)) bus ();
  prog_clock_div #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DD)) dut (.clkIn(clkIn), .rst(rst), .bus(bus));
  always #5 clkIn = ~clkIn;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: each channel wraps at absolute cycle numbers, next = previous + div + 1
  longint cyc = 0;
  longint mNext[CH];
  int mDiv[CH], mPendDiv[CH];
  bit mMode[CH], mPendMode[CH], mPendValid[CH], mOut[CH], mRun[CH];
  bit modelLive = 0;
  always @(posedge clkIn) begin
    cyc++;
    if (rst) begin
      modelLive = 1;
      for (int i = 0; i < CH; i++) begin
        mDiv[i] = DD; mMode[i] = 0; mPendValid[i] = 0; mOut[i] = 0; mRun[i] = 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        bit acc, wrap, app;
        acc = bus.loadValid && bus.loadChan == 4'(i) && !mPendValid[i];
        wrap = 0;
        app = 0;
        if (!bus.enable[i]) begin
          mRun[i] = 0; mOut[i] = 0; app = mPendValid[i];
        end else begin
          if (!mRun[i]) begin mRun[i] = 1; mNext[i] = cyc + mDiv[i]; end
          wrap = (cyc == mNext[i]);
          app = wrap && mPendValid[i];
          if (mMode[i]) mOut[i] = wrap;
          else if (wrap) mOut[i] = !mOut[i];
        end
        if (app) begin
          if (mPendMode[i] != mMode[i]) mOut[i] = 0;
          mDiv[i] = mPendDiv[i]; mMode[i] = mPendMode[i]; mPendValid[i] = 0;
        end
        if (wrap) mNext[i] = cyc + mDiv[i] + 1;
        if (acc) begin
          mPendDiv[i] = int'(bus.loadDiv); mPendMode[i] = bus.loadMode; mPendValid[i] = 1;
        end
      end
    end
  end

  always @(posedge clkIn) begin
    logic [CH-1:0] expOut;
    logic expRdy;
    #1;
    if (modelLive) begin
      for (int i = 0; i < CH; i++) expOut[i] = mOut[i];
      expRdy = !rst && bus.loadChan < 4'(CH) && !mPendValid[bus.loadChan[1:0]];
      check("clkOut", 32'(bus.clkOut), 32'(expOut));
      check("loadReady", 32'(bus.loadReady), 32'(expRdy));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clkIn);
  endtask

  task automatic waitOut(input int ch, input logic val, output int n);
    n = 0;
    do begin
      @(negedge clkIn);
      n++;
    end while (bus.clkOut[ch] !== val && n < 200);
  endtask

  initial begin
    int n, a, b, trans;
    logic [3:0] pat;
    logic prev;
    rst = 1;
    bus.enable = '1; bus.loadValid = 0; bus.loadChan = 0; bus.loadDiv = '0; bus.loadMode = 0;
    cycles(3);
    check("resetOut", 32'(bus.clkOut), 32'h0);
    check("resetReady", 32'(bus.loadReady), 32'h0);
    rst = 0;
    waitOut(0, 1, n);
    check("firstRise", n, 11);
    waitOut(0, 0, a);
    waitOut(0, 1, b);
    check("period", a + b, 22);
    bus.loadValid = 1; bus.loadChan = 1; bus.loadDiv = 3; bus.loadMode = 1;
    #1 check("readyIdle", 32'(bus.loadReady), 32'h1);
    @(negedge clkIn);
    bus.loadDiv = 7; bus.loadMode = 0;
    #1 check("readyPending", 32'(bus.loadReady), 32'h0);
    n = 0;
    do begin
      @(negedge clkIn);
      #1 n++;
    end while (!bus.loadReady && n < 100);
    bus.loadValid = 0;
    check("readyReturns", 32'(n < 100), 32'h1);
    waitOut(1, 1, n);
    check("pulseFirst", n, 4);
    pat = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clkIn);
      pat = {pat[2:0], bus.clkOut[1]};
    end
    check("pulsePattern", 32'(pat), 32'h1);
    bus.loadValid = 1; bus.loadChan = 2; bus.loadDiv = 0; bus.loadMode = 0;
    @(negedge clkIn);
    bus.loadChan = 3; bus.loadMode = 1;
    @(negedge clkIn);
    bus.loadValid = 0;
    cycles(25);
    trans = 0;
    prev = bus.clkOut[2];
    for (int i = 0; i < 6; i++) begin
      @(negedge clkIn);
      if (bus.clkOut[2] !== prev) trans++;
      prev = bus.clkOut[2];
      check("div0Pulse", 32'(bus.clkOut[3]), 32'h1);
    end
    check("div0Toggle", trans, 6);
    bus.enable[2] = 0;
    @(negedge clkIn);
    check("disabledOut", 32'(bus.clkOut[2]), 32'h0);
    bus.loadValid = 1; bus.loadChan = 2; bus.loadDiv = 5; bus.loadMode = 0;
    #1 check("readyDisabled", 32'(bus.loadReady), 32'h1);
    @(negedge clkIn);
    bus.loadValid = 0;
    cycles(3);
    check("stillLow", 32'(bus.clkOut[2]), 32'h0);
    bus.enable[2] = 1;
    waitOut(2, 1, n);
    check("reenableRise", n, 6);
    bus.loadValid = 1; bus.loadChan = 7;
    #1 check("outOfRange", 32'(bus.loadReady), 32'h0);
    @(negedge clkIn);
    bus.loadValid = 0;
    cycles(7);
    rst = 1;
    bus.loadValid = 1; bus.loadChan = 0; bus.loadDiv = 2; bus.loadMode = 1;
    #1 check("readyInReset", 32'(bus.loadReady), 32'h0);
    @(negedge clkIn);
    check("midReset", 32'(bus.clkOut), 32'h0);
    rst = 0;
    bus.loadValid = 0;
    #1 check("noPendingAfterRst", 32'(bus.loadReady), 32'h1);
    waitOut(0, 1, n);
    check("rstRise", n, 11);
    cycles(30);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
